// File: rtl/cs_rot_ctrl.sv
// rtl/cs_rot_ctrl.sv - sequencing controller for the circular shift register datapath
// Loads an operand, rotates it one bit per clock for a captured count, and reports completion.
module cs_rot_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] amount,
  input  logic             dir,
  input  logic             abort,
  input  logic             clear,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] remaining_q;
  logic             dir_q;
  logic             last_step;

  assign last_step = (remaining_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort || last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // start takes priority over clear when both are presented
          if (start) begin
            result_q    <= load_val;
            remaining_q <= amount;
            dir_q       <= dir;
          end else if (clear) begin
            result_q <= '0;
          end
        end
        SHIFT: begin
          // an aborted edge performs no rotation and keeps the pending count
          if (!abort && remaining_q != '0) begin
            if (dir_q) begin
              result_q <= {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            end else begin
              result_q <= {result_q[0], result_q[WIDTH-1:1]};
            end
            remaining_q <= remaining_q - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_cs_rot_ctrl.sv
// tb/tb_cs_rot_ctrl.sv - directed self-checking bench for cs_rot_ctrl
module tb_cs_rot_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] load_val;
  logic [4:0]  amount;
  logic        dir;
  logic        abort;
  logic        clear;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  remaining;

  int checks;
  int errors;
  int lat;
  int busy_n;
  int saw_done;

  cs_rot_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .load_val  (load_val),
    .amount    (amount),
    .dir       (dir),
    .abort     (abort),
    .clear     (clear),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .remaining (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // presents a request and steps past the accepting edge E0
  task automatic start_op(input logic [31:0] v, input logic [4:0] n, input logic d);
    load_val = v;
    amount   = n;
    dir      = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // after E0: counts edges until done is seen, and SHIFT cycles along the way
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!done && l < 64) begin
      if (busy) b++;
      tick();
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] v, input logic [4:0] n,
                        input logic d, input logic [31:0] exp);
    start_op(v, n, d);
    wait_done(lat, busy_n);
    check_val({tag, "_lat"}, lat, n);
    check_val({tag, "_busy"}, busy_n, n);
    check_val({tag, "_res"}, result, exp);
    check_val({tag, "_rem"}, remaining, 0);
    tick();
    check_val({tag, "_done_pulse"}, done, 0);
    check_val({tag, "_ready"}, ready, 1);
    check_val({tag, "_res_idle"}, result, exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; load_val = '0; amount = '0;
    dir = 1'b0; abort = 1'b0; clear = 1'b0;
    tick();
    tick();
    check_val("rst_ready", ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_remaining", remaining, 0);
    reset = 1'b0;
    tick();

    run_op("r1", 32'h0000_0001, 5'd1, 1'b0, 32'h8000_0000);
    run_op("l4", 32'h1234_5678, 5'd4, 1'b1, 32'h2345_6781);
    run_op("r4", 32'h1234_5678, 5'd4, 1'b0, 32'h8123_4567);
    run_op("r31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    run_op("l31", 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000);
    run_op("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF);

    // abort sampled at E3 of a 10-step left rotation
    start_op(32'h0000_0001, 5'd10, 1'b1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_done", done, 1);
    check_val("abort_res", result, 32'h0000_0004);
    check_val("abort_rem", remaining, 8);
    tick();
    check_val("abort_ready", ready, 1);
    check_val("abort_done_pulse", done, 0);

    // start and clear during SHIFT are ignored
    start_op(32'h1234_5678, 5'd4, 1'b1);
    load_val = 32'hFFFF_0000;
    amount   = 5'd1;
    start    = 1'b1;
    clear    = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    wait_done(lat, busy_n);
    check_val("ign_lat", lat + 1, 4);
    check_val("ign_res", result, 32'h2345_6781);
    tick();
    check_val("ign_ready", ready, 1);

    // clear together with start in IDLE: start wins
    clear = 1'b1;
    start_op(32'hA5A5_A5A5, 5'd0, 1'b0);
    clear = 1'b0;
    check_val("clrst_done", done, 1);
    check_val("clrst_res", result, 32'hA5A5_A5A5);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("clr_res", result, 0);
    check_val("clr_ready", ready, 1);

    // reset at E3 of a 10-step operation
    start_op(32'h0F0F_0F0F, 5'd10, 1'b0);
    tick();
    tick();
    check_val("midrst_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("midrst_ready", ready, 1);
    check_val("midrst_result", result, 0);
    check_val("midrst_remaining", remaining, 0);
    saw_done = 0;
    if (done) saw_done = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) saw_done = 1;
    end
    check_val("midrst_nodone", saw_done, 0);

    // latched dir returns to right after reset
    run_op("post_rst", 32'h0000_0002, 5'd1, 1'b0, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
